// File: rtl/onp_pkg.sv
// onp_pkg: constants and types shared by the ONP evaluator blocks.
//   ARB_INIT/ARB_IDLE/ARB_ISSUE : fifo_arb state encodings
//   ONP_FIFO_DEPTH              : depth of the evaluator fifo (16)
//   ARB_N_MAX                   : largest supported fifo_arb requester count
//   arb_ptr_w()                 : width of a requester index for n requesters
// Configuration macro consumed by users of this package: FIFO_ARB_FIXED_PRIO_EN.
package onp_pkg;

  localparam int ONP_FIFO_DEPTH = 16;
  localparam int ARB_N_MAX      = 8;

  typedef enum logic [1:0] {
    ARB_INIT  = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_ISSUE = 2'd2
  } arb_state_t;

  function automatic int arb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// rr_pick: combinational winner selection for fifo_arb.
//   i_req   [N]  : request vector
//   i_ptr   [PW] : index of the previous winner (round-robin build only)
//   o_valid      : at least one request is set
//   o_idx   [PW] : winning requester index
// Macro FIFO_ARB_FIXED_PRIO_EN: when defined the lowest set index wins and
// there is no i_ptr port; otherwise the search starts at i_ptr+1, modulo N.
module rr_pick
  import onp_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = arb_ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
`ifndef FIFO_ARB_FIXED_PRIO_EN
  input  logic [PW-1:0] i_ptr,
`endif
  output logic          o_valid,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] w_cand;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = N; k > 0; k--) begin
      w_cand = PW'(k - 1);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end
`else
  // Candidates ptr+N down to ptr+1 (mod N): the one nearest above ptr is
  // written last and wins; the previous winner itself has lowest priority.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = N; k > 0; k--) begin
      w_cand = PW'((32'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_arb.sv
// fifo_arb: write arbiter sharing the single input port of the 16-entry
// fifo between N producers.
//   CLK, RST_N        : clock (rising edge), asynchronous active-low reset
//   REQ_STB [N]       : per-requester request level, held until REQ_ACK
//   REQ_DAT [N*WIDTH] : requester i word at [i*WIDTH +: WIDTH]
//   REQ_ACK [N]       : one-cycle pulse, word of requester i taken
//   FI_STB, FI_DAT    : fifo write strobe / data (registered)
//   FI_BSY            : fifo full
// At most one write every two cycles: the IDLE cycle after each write lets
// FI_BSY reflect that write before the next grant, so a full fifo is never
// written and an acknowledged requester is never granted twice.
// Macro FIFO_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins, no
// round-robin pointer); default build is round-robin.
module fifo_arb
  import onp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N-1:0]       REQ_STB,
  input  logic [N*WIDTH-1:0] REQ_DAT,
  output logic [N-1:0]       REQ_ACK,
  output logic               FI_STB,
  output logic [WIDTH-1:0]   FI_DAT,
  input  logic               FI_BSY
);

  localparam int PW = arb_ptr_w(N);

  if (N < 2 || N > ARB_N_MAX) begin : g_bad_n
    $error("fifo_arb: N must be in 2..%0d", ARB_N_MAX);
  end

  arb_state_t       r_state;
  logic             r_fi_stb;
  logic [WIDTH-1:0] r_fi_dat;
  logic [N-1:0]     r_ack;

  logic             w_valid;
  logic [PW-1:0]    w_win;
  logic             w_grant;
  logic [WIDTH-1:0] w_win_dat;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req   (REQ_STB),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );
`else
  logic [PW-1:0] r_ptr;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req   (REQ_STB),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= PW'(N - 1);
    end else if (w_grant) begin
      r_ptr <= w_win;
    end
  end
`endif

  // FI_BSY has priority over any pending request.
  assign w_grant = (r_state == ARB_IDLE) && w_valid && !FI_BSY;

  always_comb begin
    w_win_dat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_win == PW'(i)) begin
        w_win_dat = REQ_DAT[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ARB_INIT;
      r_fi_stb <= 1'b0;
      r_fi_dat <= '0;
      r_ack    <= '0;
    end else begin
      case (r_state)
        ARB_INIT: begin
          r_state  <= ARB_IDLE;
          r_fi_stb <= 1'b0;
          r_ack    <= '0;
        end
        ARB_IDLE: begin
          if (w_grant) begin
            r_state       <= ARB_ISSUE;
            r_fi_stb      <= 1'b1;
            r_fi_dat      <= w_win_dat;
            r_ack         <= '0;
            r_ack[w_win]  <= 1'b1;
          end
        end
        ARB_ISSUE: begin
          r_state  <= ARB_IDLE;
          r_fi_stb <= 1'b0;
          r_ack    <= '0;
        end
        default: begin
          r_state  <= ARB_INIT;
          r_fi_stb <= 1'b0;
          r_ack    <= '0;
        end
      endcase
    end
  end

  assign FI_STB  = r_fi_stb;
  assign FI_DAT  = r_fi_dat;
  assign REQ_ACK = r_ack;

endmodule

// File: tb/tb_fifo_arb.sv
// tb_fifo_arb: self-checking bench for fifo_arb (N=4, WIDTH=8) with a
// behavioural 16-entry fifo and a queue-based reference of the arbitration
// rules. Honours FIFO_ARB_FIXED_PRIO_EN for its expectations.
module tb_fifo_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_stb;
  logic [31:0] req_dat;
  logic [3:0]  req_ack;
  logic        fi_stb;
  logic [7:0]  fi_dat;
  logic        fi_bsy;
  logic        fo_ack;

  fifo_arb #(
    .WIDTH (8),
    .N     (4)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .REQ_STB (req_stb),
    .REQ_DAT (req_dat),
    .REQ_ACK (req_ack),
    .FI_STB  (fi_stb),
    .FI_DAT  (fi_dat),
    .FI_BSY  (fi_bsy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus sources and reference state
  logic [7:0] src_q [4][$];
  logic [7:0] fq [$];
  logic [7:0] exp_wr [$];
  int         grant_q [$];
  int         stb_cyc [$];
  int         stb_cnt = 0;
  int         cyc = 0;
  int         fo_mode = 0;
  bit         rand_gen = 0;

  function automatic int pick(input logic [3:0] req, input int last);
    int w;
    w = -1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (req[k]) w = k;
`else
    for (int k = 4; k >= 1; k--) if (req[(last + k) % 4]) w = (last + k) % 4;
`endif
    return w;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Behavioural fifo: pop before push, full at 16 entries.
  always @(posedge clk or negedge rst_n) begin
    int e;
    logic [7:0] w;
    if (!rst_n) begin
      fq.delete();
      fi_bsy <= 1'b0;
    end else begin
      if (fo_ack && fq.size() > 0) begin
        w = fq.pop_front();
        e = (exp_wr.size() > 0) ? int'(exp_wr.pop_front()) : -1;
        chk("rd_order", int'(w), e);
      end
      if (fi_stb) begin
        chk("no_write_when_full", int'(fq.size() < 16), 1);
        if (fq.size() < 16) fq.push_back(fi_dat);
      end
      fi_bsy <= (fq.size() == 16);
    end
  end

  // Reference: a grant needs a pending request, a non-full fifo, and neither
  // the INIT cycle nor a write in the previous cycle.
  bit         m_init = 1;
  bit         m_stb = 0;
  logic [3:0] m_ack = '0;
  logic [7:0] m_dat = '0;
  int         m_last = 3;
  logic [3:0] m_prev_req = '0;

  always @(negedge clk) begin
    int g;
    cyc++;
    if (!rst_n) begin
      chk("rst_fi_stb", fi_stb, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_fi_dat", fi_dat, 0);
      m_init = 1; m_stb = 0; m_ack = '0; m_dat = '0; m_last = 3;
      m_prev_req = '0;
      exp_wr.delete();
    end else begin
      chk("mon_fi_stb", fi_stb, m_stb);
      chk("mon_req_ack", req_ack, m_ack);
      if (m_stb) chk("mon_fi_dat", fi_dat, m_dat);
      if (fi_stb) begin
        stb_cnt++;
        stb_cyc.push_back(cyc);
        for (int i = 0; i < 4; i++) if (req_ack[i]) grant_q.push_back(i);
      end
      for (int i = 0; i < 4; i++)
        if (m_prev_req[i]) chk($sformatf("hold_until_ack%0d", i), req_stb[i] | req_ack[i], 1);
      if (m_init) begin
        m_init = 0; m_stb = 0; m_ack = '0;
      end else if (!m_stb && req_stb != 4'b0 && !fi_bsy) begin
        g = pick(req_stb, m_last);
        m_stb = 1;
        m_ack = 4'b0001 << g;
        m_dat = (src_q[g].size() > 0) ? src_q[g][0] : 8'h00;
        m_last = g;
        exp_wr.push_back(m_dat);
      end else begin
        m_stb = 0; m_ack = '0;
      end
      m_prev_req = req_stb;
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        req_stb[i] = 1'b1;
        req_dat[i*8 +: 8] = src_q[i][0];
      end else begin
        req_stb[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (rand_gen) begin
      for (int i = 0; i < 4; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) src_q[i].push_back(8'($urandom_range(0, 255)));
        end
      end
    end
    drive();
    if (fo_mode == 1) fo_ack = (fq.size() > 0);
    else if (fo_mode == 2) fo_ack = ($urandom_range(0, 2) == 0);
  endtask

  function automatic bit busy();
    bit b;
    b = fi_stb;
    for (int i = 0; i < 4; i++) if (src_q[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (busy() && k < limit) begin
      step();
      k++;
    end
    chk(name, busy(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    drive();
    fo_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fi_stb", fi_stb, 0);
    chk("reset_req_ack", req_ack, 0);
    chk("reset_fi_dat", fi_dat, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] stb;
    logic [7:0] base;
    logic [3:0] exp_rr;
    logic [3:0] exp_fx;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [3:0] ex;
    int exp_g;

    tbl[0] = '{4'b0001, 8'h5A, 4'b0001, 4'b0001};
    tbl[1] = '{4'b0011, 8'h20, 4'b0010, 4'b0001};
    tbl[2] = '{4'b0110, 8'h30, 4'b0010, 4'b0010};
    tbl[3] = '{4'b1001, 8'h40, 4'b1000, 4'b0001};
    tbl[4] = '{4'b1100, 8'h50, 4'b0100, 4'b0100};
    tbl[5] = '{4'b1111, 8'h60, 4'b0001, 4'b0001};
    tbl[6] = '{4'b0101, 8'h70, 4'b0001, 4'b0001};
    tbl[7] = '{4'b1010, 8'h80, 4'b1000, 4'b0010};
    tbl[8] = '{4'b0010, 8'h90, 4'b0010, 4'b0010};

    rst_n   = 1'b0;
    req_stb = '0;
    req_dat = '0;
    fo_ack  = 1'b0;

    // Single requests and two-way contention from a known pointer
    do_reset();
    fo_mode = 1;
    repeat (3) step();
    chk("init_idle_no_stb", fi_stb, 0);
    for (int v = 0; v < 9; v++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      ex = tbl[v].exp_fx;
`else
      ex = tbl[v].exp_rr;
`endif
      for (int i = 0; i < 4; i++)
        if (tbl[v].stb[i]) src_q[i].push_back(tbl[v].base + 8'(i));
      drive();
      step();
      chk($sformatf("tbl%0d_fi_stb", v), fi_stb, 1);
      chk($sformatf("tbl%0d_req_ack", v), req_ack, ex);
      chk($sformatf("tbl%0d_fi_dat", v), fi_dat, tbl[v].base + 8'(oh_idx(ex)));
      step();
      chk($sformatf("tbl%0d_ack_one_cycle", v), req_ack & ex, 0);
      wait_idle($sformatf("tbl%0d_drain_timeout", v), 40);
    end

    // Full contention, 8 words per requester
    do_reset();
    step();
    grant_q.delete();
    stb_cyc.delete();
    for (int i = 0; i < 4; i++) repeat (8) src_q[i].push_back(8'h10 + 8'(i));
    drive();
    wait_idle("cont_timeout", 120);
    chk("cont_count", grant_q.size(), 32);
    for (int j = 0; j < grant_q.size(); j++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      exp_g = j / 8;
`else
      exp_g = j % 4;
`endif
      chk($sformatf("cont_grant%0d", j), grant_q[j], exp_g);
      if (j > 0) chk($sformatf("cont_spacing%0d", j), stb_cyc[j] - stb_cyc[j-1], 2);
    end

    // Fill to full with no reads
    do_reset();
    fo_mode = 0;
    fo_ack = 1'b0;
    step();
    stb_cnt = 0;
    for (int w = 0; w < 20; w++) src_q[1].push_back(8'(w));
    drive();
    repeat (60) step();
    chk("fill_stb_count", stb_cnt, 16);
    chk("fill_bsy", fi_bsy, 1);
    chk("fill_pending_word", src_q[1].size() > 0 ? int'(src_q[1][0]) : -1, 'h10);
    fo_ack = 1'b1;
    step();
    chk("fill_no_stb_on_read", fi_stb, 0);
    fo_ack = 1'b0;
    step();
    chk("fill_resume_stb", fi_stb, 1);
    chk("fill_resume_dat", fi_dat, 'h10);
    chk("fill_resume_ack", req_ack, 4'b0010);
    step();
    chk("full_again", fi_bsy, 1);

    // Full, read and request in the same cycle
    fo_ack = 1'b1;
    step();
    chk("simul_no_stb", fi_stb, 0);
    fo_ack = 1'b0;
    step();
    chk("simul_stb", fi_stb, 1);
    chk("simul_dat", fi_dat, 'h11);
    fo_mode = 1;
    wait_idle("fill_drain_timeout", 100);
    repeat (20) step();
    chk("fill_fifo_empty", fq.size(), 0);

    // Reset in the middle of a write
    src_q[2].push_back(8'h77);
    drive();
    step();
    chk("midrst_pre_ack", req_ack, 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_fi_stb", fi_stb, 0);
    chk("midrst_req_ack", req_ack, 0);
    chk("midrst_fi_dat", fi_dat, 0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    drive();
    repeat (2) step();
    src_q[0].push_back(8'hA0);
    src_q[2].push_back(8'hA2);
    drive();
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_init_cycle", fi_stb, 0);
    step();
    chk("midrst_first_stb", fi_stb, 1);
    chk("midrst_first_ack", req_ack, 4'b0001);
    chk("midrst_first_dat", fi_dat, 'hA0);
    wait_idle("midrst_drain_timeout", 40);

    // Random traffic with random reads
    rand_gen = 1;
    fo_mode = 2;
    repeat (400) step();
    rand_gen = 0;
    fo_mode = 1;
    wait_idle("rand_drain_timeout", 200);
    repeat (20) step();
    chk("final_fifo_empty", fq.size(), 0);
    chk("final_all_read", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
